// File: rtl/mem_responder.sv
// Word-organised data memory for the multicycle core: accepts mem_read/mem_write in IDLE,
// waits WAIT_CYCLES, commits on the edge into RESP and answers with a one-cycle ready pulse.
module mem_responder #(
    parameter int DEPTH_WORDS = 1024,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic [3:0]  wstrb,
    output logic [31:0] rdata,
    output logic        ready,
    output logic        err,
    output logic        busy
);

    localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

    // Handshake: a request is any strobe high at a rising edge while IDLE; the response
    // is ready=1 for exactly one cycle, with err and rdata valid in that same cycle.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t        state, state_nx;
    logic [3:0]    cnt, cnt_nx;

    logic [31:0]   mem [DEPTH_WORDS];

    logic [AW-1:0] idx_q;
    logic [31:0]   wdata_q;
    logic [3:0]    wstrb_q;
    logic          write_q;
    logic          err_q;

    logic          req;
    logic          req_err;

    logic          commit;
    logic [AW-1:0] c_idx;
    logic [31:0]   c_wdata;
    logic [3:0]    c_wstrb;
    logic          c_write;
    logic          c_err;

    assign req     = mem_read | mem_write;
    assign req_err = (addr[1:0] != 2'b00)
                   | ({2'b00, addr[31:2]} >= 32'(DEPTH_WORDS))
                   | (mem_read & mem_write);

    // With zero wait states the acceptance edge is also the commit edge, so the commit
    // operands come straight from the ports instead of the latched copies.
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        commit   = 1'b0;
        c_idx    = idx_q;
        c_wdata  = wdata_q;
        c_wstrb  = wstrb_q;
        c_write  = write_q;
        c_err    = err_q;
        case (state)
            IDLE: begin
                if (req) begin
                    cnt_nx = 4'(WAIT_CYCLES);
                    if (WAIT_CYCLES > 0) begin
                        state_nx = WAIT;
                    end else begin
                        state_nx = RESP;
                        commit   = 1'b1;
                        c_idx    = addr[AW+1:2];
                        c_wdata  = wdata;
                        c_wstrb  = wstrb;
                        c_write  = mem_write;
                        c_err    = req_err;
                    end
                end
            end
            WAIT: begin
                cnt_nx = cnt - 4'd1;
                if (cnt <= 4'd1) begin
                    state_nx = RESP;
                    commit   = 1'b1;
                end
            end
            RESP: begin
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state   <= IDLE;
            cnt     <= 4'd0;
            rdata   <= 32'd0;
            idx_q   <= '0;
            wdata_q <= 32'd0;
            wstrb_q <= 4'd0;
            write_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            if (state == IDLE && req) begin
                idx_q   <= addr[AW+1:2];
                wdata_q <= wdata;
                wstrb_q <= wstrb;
                write_q <= mem_write;
                err_q   <= req_err;
            end
            if (commit && (c_err || !c_write)) begin
                rdata <= c_err ? 32'd0 : mem[c_idx];
            end
        end
    end

    // Array is never reset; gating with resetn drops a write whose commit edge sees reset.
    always_ff @(posedge clk) begin
        if (resetn && commit && c_write && !c_err) begin
            for (int i = 0; i < 4; i++) begin
                if (c_wstrb[i]) begin
                    mem[c_idx][8*i +: 8] <= c_wdata[8*i +: 8];
                end
            end
        end
    end

    assign ready = (state == RESP);
    assign err   = ready & err_q;
    assign busy  = (state != IDLE);

endmodule

// File: doc/mem_responder.md
Name: mem_responder

Overview:
- Word-organised data memory that services the multicycle core's mem_read / mem_write strobes.
- Sits between the control unit / datapath and on-chip RAM.
- Adds configurable wait states and a one-cycle ready pulse, so the core can stall in MEM_RD / MEM_WR until the access completes.
- Flags misaligned, out-of-range and conflicting requests with an error response instead of corrupting memory.

Parameters:
- DEPTH_WORDS, 1024: number of 32-bit words in the internal array; valid byte addresses are 0 .. 4*DEPTH_WORDS-1.
- WAIT_CYCLES, 2: extra cycles between request acceptance and response, legal range 0..15.

Ports:
- clk  input  1  clock
- resetn  input  1  reset, synchronous, active-low
- mem_read  input  1  read request strobe, level
- mem_write  input  1  write request strobe, level
- addr  input  32  byte address, word aligned
- wdata  input  32  write data
- wstrb  input  4  byte-lane write enables; bit i selects wdata[8i+7:8i]
- rdata  output  32  read data, registered
- ready  output  1  one-cycle response pulse
- err  output  1  error qualifier, meaningful only while ready=1
- busy  output  1  high whenever state != IDLE

Behaviour:
- Reset (resetn=0 at a rising edge):
  - state=IDLE, ready=0, err=0, rdata=0, busy=0, wait counter=0.
  - Memory array contents are not reset.
- States: IDLE, WAIT, RESP.
- IDLE:
  - Strobes are sampled only in IDLE.
  - If mem_read or mem_write is high at a rising edge, latch addr, wdata, wstrb and op, then load the counter with WAIT_CYCLES.
  - Next state is WAIT if WAIT_CYCLES>0, else RESP.
  - With no strobe high, stay in IDLE.
- WAIT:
  - Counter decrements each cycle.
  - When counter==1, move to RESP at that edge.
  - Strobes and addr are ignored (latched copies are used).
- Commit edge: the edge entering RESP.
  - Write: bytes with wstrb[i]=1 are written; other bytes are unchanged. wstrb=0000 is a legal no-op write and still returns ready.
  - Read: rdata is loaded with mem[addr[31:2]].
- RESP:
  - ready=1 for exactly one cycle, then unconditional return to IDLE.
- Latency: request high in IDLE in cycle t gives ready=1 in cycle t+1+WAIT_CYCLES.
  - WAIT_CYCLES=0: ready in t+1.
  - WAIT_CYCLES=2: ready in t+3.
- Back-to-back requests: a strobe still high in the IDLE cycle after RESP is a new request.
  - The requester must deassert in the cycle after ready unless it intends a new access.
  - Minimum spacing is WAIT_CYCLES+2 cycles per access.
- Error conditions, checked on latched values at acceptance:
  - addr[1:0]!=0, or addr[31:2]>=DEPTH_WORDS, or mem_read and mem_write both high.
  - Response: same latency, ready=1 with err=1; no array write; rdata forced to 0.
- err=0 on every non-error response; err=0 whenever ready=0.
- rdata changes only at the commit edge of a read or error response and holds otherwise, including across writes.
- Read-after-write: a read accepted after a write's RESP returns the written data.
- Reset mid-operation:
  - Asserting reset in WAIT abandons the access; the pending write is not committed.
  - Asserting reset on the commit edge itself suppresses the write.
- busy=1 from the cycle after acceptance through the RESP cycle inclusive.

Test Plan:
- Aligned write, then read (WAIT_CYCLES=2): mem_write, addr=0x10, wdata=0xDEADBEEF, wstrb=1111, ready in t+3 with err=0; then mem_read addr=0x10 gives rdata=0xDEADBEEF, ready 3 cycles after acceptance, busy high for 3 cycles.
- Byte strobes: word 0x20 preloaded 0x11223344, write wdata=0xAABBCCDD, wstrb=0101, then read returns 0x11BB33DD.
- Errors:
  - Read addr=0x12 gives ready with err=1, rdata=0.
  - Write addr=4*DEPTH_WORDS gives err=1 and a subsequent read of word 0 is unchanged.
  - Both strobes high gives err=1 and no write.
- Zero wait and back-to-back (WAIT_CYCLES=0): mem_read held high for 4 cycles gives ready in cycles t+1 and t+3 (two accesses), ready never high on consecutive cycles.
- Reset mid-write: write 0xCAFEF00D to 0x40 accepted, resetn=0 in first WAIT cycle; after reset state=IDLE, ready=0, rdata=0, and a read of 0x40 returns the old contents.
